// File: rtl/snn_layer_scheduler.sv
// snn_layer_scheduler: time-multiplexes a single external neuron datapath
// across a fully-connected layer of N_OUT neurons for one timestep.
// For each neuron j it walks all N_IN inputs. Every spiking input triggers a
// weight fetch followed by an add. One decay/threshold step then closes the
// neuron. Membrane potentials and output spikes are held locally.
module snn_layer_scheduler #(
    parameter int SIZE    = 8,
    parameter int N_IN    = 16,
    parameter int N_OUT   = 8,
    parameter int WADDR_W = $clog2(N_IN * N_OUT),
    parameter int IDX_W   = $clog2(N_OUT)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start,
    input  logic               clear_vmem,
    input  logic [N_IN-1:0]    in_spikes,
    input  logic [SIZE-1:0]    beta,
    input  logic [SIZE-1:0]    v_th,
    output logic               busy,
    output logic               done,
    output logic [N_OUT-1:0]   out_spikes,
    output logic               w_rd_en,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [SIZE-1:0]    w_rdata,
    output logic [SIZE-1:0]    nrn_weight,
    output logic [SIZE-1:0]    nrn_v_mem_in,
    output logic [SIZE-1:0]    nrn_beta,
    output logic [SIZE-1:0]    nrn_v_th,
    output logic               nrn_function_sel,
    input  logic               nrn_spike,
    input  logic [SIZE-1:0]    nrn_v_mem_out,
    input  logic [IDX_W-1:0]   vmem_rd_idx,
    output logic [SIZE-1:0]    vmem_rd_data
);

    localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [I_W-1:0]     I_LAST = I_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]   J_LAST = IDX_W'(N_OUT - 1);
    localparam logic [WADDR_W-1:0] ROW    = WADDR_W'(N_IN);

    typedef enum logic [2:0] {IDLE, SCAN, ACCUM, DECAY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [I_W-1:0]   i_reg, i_next;
    logic [IDX_W-1:0] j_reg, j_next;
    logic [N_IN-1:0]  spk_q;
    logic [SIZE-1:0]  beta_q;
    logic [SIZE-1:0]  vth_q;
    logic [SIZE-1:0]  vmem [N_OUT];
    logic [N_OUT-1:0] spikes_reg;
    logic             clear_ok;
    logic             start_ok;
    logic             vmem_we;

    // Clear has priority over start when both arrive in IDLE.
    assign clear_ok = (state_reg == IDLE) && clear_vmem;
    assign start_ok = (state_reg == IDLE) && !clear_vmem && start;
    assign vmem_we  = (state_reg == ACCUM) || (state_reg == DECAY);

    assign busy         = (state_reg == SCAN) || (state_reg == ACCUM) || (state_reg == DECAY);
    assign done         = (state_reg == DONE);
    assign out_spikes   = spikes_reg;
    assign w_addr       = WADDR_W'(j_reg) * ROW + WADDR_W'(i_reg);
    assign nrn_v_mem_in = vmem[j_reg];
    assign nrn_beta     = beta_q;
    assign nrn_v_th     = vth_q;

    // State and loop-counter registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
        end
    end

    // Next-state logic plus the read strobe and neuron control outputs.
    always_comb begin
        state_next       = state_reg;
        i_next           = i_reg;
        j_next           = j_reg;
        w_rd_en          = 1'b0;
        nrn_weight       = '0;
        nrn_function_sel = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next = SCAN;
                    i_next     = '0;
                    j_next     = '0;
                end
            end
            SCAN: begin
                if (spk_q[i_reg]) begin
                    // The weight arrives next cycle, when ACCUM consumes it.
                    w_rd_en    = 1'b1;
                    state_next = ACCUM;
                end else if (i_reg == I_LAST) begin
                    state_next = DECAY;
                end else begin
                    i_next = i_reg + 1'b1;
                end
            end
            ACCUM: begin
                nrn_weight = w_rdata;
                if (i_reg == I_LAST) begin
                    state_next = DECAY;
                end else begin
                    i_next     = i_reg + 1'b1;
                    state_next = SCAN;
                end
            end
            DECAY: begin
                nrn_function_sel = 1'b1;
                if (j_reg == J_LAST) begin
                    state_next = DONE;
                end else begin
                    j_next     = j_reg + 1'b1;
                    i_next     = '0;
                    state_next = SCAN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-timestep operands, captured only when a run is accepted.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            spk_q  <= '0;
            beta_q <= '0;
            vth_q  <= '0;
        end else if (start_ok) begin
            spk_q  <= in_spikes;
            beta_q <= beta;
            vth_q  <= v_th;
        end
    end

    // Membrane state and spike vector; the neuron result is stored as produced.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < N_OUT; k++) begin
                vmem[k] <= '0;
            end
            spikes_reg <= '0;
        end else if (clear_ok) begin
            for (int k = 0; k < N_OUT; k++) begin
                vmem[k] <= '0;
            end
            spikes_reg <= '0;
        end else begin
            if (vmem_we) begin
                vmem[j_reg] <= nrn_v_mem_out;
            end
            if (state_reg == DECAY) begin
                spikes_reg[j_reg] <= nrn_spike;
            end
        end
    end

    // Debug readout; a same-cycle write is seen one cycle later.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            vmem_rd_data <= '0;
        end else begin
            vmem_rd_data <= vmem[vmem_rd_idx];
        end
    end

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// Directed bench for snn_layer_scheduler with a behavioural neuron and a
// registered weight memory attached.
module tb_snn_layer_scheduler;

    localparam int SIZE    = 8;
    localparam int N_IN    = 16;
    localparam int N_OUT   = 8;
    localparam int WADDR_W = 7;
    localparam int IDX_W   = 3;

    logic               clk;
    logic               rst;
    logic               start;
    logic               clear_vmem;
    logic [N_IN-1:0]    in_spikes;
    logic [SIZE-1:0]    beta;
    logic [SIZE-1:0]    v_th;
    logic               busy;
    logic               done;
    logic [N_OUT-1:0]   out_spikes;
    logic               w_rd_en;
    logic [WADDR_W-1:0] w_addr;
    logic [SIZE-1:0]    w_rdata;
    logic [SIZE-1:0]    nrn_weight;
    logic [SIZE-1:0]    nrn_v_mem_in;
    logic [SIZE-1:0]    nrn_beta;
    logic [SIZE-1:0]    nrn_v_th;
    logic               nrn_function_sel;
    logic               nrn_spike;
    logic [SIZE-1:0]    nrn_v_mem_out;
    logic [IDX_W-1:0]   vmem_rd_idx;
    logic [SIZE-1:0]    vmem_rd_data;

    logic [SIZE-1:0]    wmem [128];
    logic [SIZE-1:0]    prod;
    int                 rd_q [$];
    int                 checks;
    int                 errors;

    snn_layer_scheduler #(
        .SIZE(SIZE), .N_IN(N_IN), .N_OUT(N_OUT), .WADDR_W(WADDR_W), .IDX_W(IDX_W)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .clear_vmem(clear_vmem),
        .in_spikes(in_spikes), .beta(beta), .v_th(v_th), .busy(busy), .done(done),
        .out_spikes(out_spikes), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .nrn_weight(nrn_weight), .nrn_v_mem_in(nrn_v_mem_in), .nrn_beta(nrn_beta),
        .nrn_v_th(nrn_v_th), .nrn_function_sel(nrn_function_sel), .nrn_spike(nrn_spike),
        .nrn_v_mem_out(nrn_v_mem_out), .vmem_rd_idx(vmem_rd_idx), .vmem_rd_data(vmem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight SRAM: one-cycle registered read.
    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= wmem[w_addr];
    end

    // Behavioural neuron: add, or multiply-decay then threshold with reset to 0.
    always_comb begin
        prod          = nrn_v_mem_in * nrn_beta;
        nrn_spike     = 1'b0;
        nrn_v_mem_out = nrn_v_mem_in + nrn_weight;
        if (nrn_function_sel) begin
            if (prod > nrn_v_th) begin
                nrn_spike     = 1'b1;
                nrn_v_mem_out = '0;
            end else begin
                nrn_v_mem_out = prod;
            end
        end
    end

    // Record every weight read address.
    always @(negedge clk) begin
        if (w_rd_en) rd_q.push_back(int'(w_addr));
    end

    task automatic read_vmem(input int idx, output logic [SIZE-1:0] val);
        vmem_rd_idx = IDX_W'(idx);
        @(posedge clk); #1;
        val = vmem_rd_data;
    endtask

    // One timestep; lat is the cycle count from the accepting edge to done.
    task automatic do_run(input logic [N_IN-1:0] spk, input logic [SIZE-1:0] b,
                          input logic [SIZE-1:0] th, input bit disturb,
                          output int lat, output int ndone);
        lat   = -1;
        ndone = 0;
        rd_q.delete();
        in_spikes = spk; beta = b; v_th = th; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = cyc;
            end
            if (disturb) begin
                if (cyc == 5)  begin start = 1'b1; in_spikes = 16'hFFFF; end
                if (cyc == 6)  start = 1'b0;
                if (cyc == 40) clear_vmem = 1'b1;
                if (cyc == 41) clear_vmem = 1'b0;
            end
            if (lat >= 0 && cyc >= lat + 4) break;
        end
        start = 1'b0; clear_vmem = 1'b0; in_spikes = spk;
        $display("run spikes=%h beta=%0d vth=%0d latency=%0d done_pulses=%0d reads=%0d out=%h",
                 spk, b, th, lat, ndone, rd_q.size(), out_spikes);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++; if (out_spikes !== 8'h00) begin errors++; $display("FAIL reset_out got %h expected 00", out_spikes); end
        checks++; if (w_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b expected 0", w_rd_en); end
        checks++; if (w_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", w_addr); end
        checks++; if (nrn_function_sel !== 1'b0) begin errors++; $display("FAIL reset_fsel got %b expected 0", nrn_function_sel); end
        checks++; if (vmem_rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data got %0d expected 0", vmem_rd_data); end
        checks++; if (nrn_beta !== 8'd0 || nrn_v_th !== 8'd0) begin errors++; $display("FAIL reset_latched got %0d/%0d expected 0/0", nrn_beta, nrn_v_th); end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_first_timestep();
        int lat, nd;
        logic [SIZE-1:0] v;
        do_run(16'h0005, 8'd1, 8'd10, 1'b0, lat, nd);
        checks++; if (lat !== 152) begin errors++; $display("FAIL first_latency got %0d expected 152", lat); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL first_done_pulses got %0d expected 1", nd); end
        checks++; if (out_spikes !== 8'h00) begin errors++; $display("FAIL first_out got %h expected 00", out_spikes); end
        read_vmem(0, v);
        checks++; if (v !== 8'd7) begin errors++; $display("FAIL first_vmem0 got %0d expected 7", v); end
        read_vmem(2, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL first_vmem2 got %0d expected 0", v); end
    endtask

    task automatic test_repeat();
        int lat, nd, exp_a;
        logic [SIZE-1:0] v;
        do_run(16'h0005, 8'd1, 8'd10, 1'b0, lat, nd);
        checks++; if (lat !== 152) begin errors++; $display("FAIL repeat_latency got %0d expected 152", lat); end
        checks++; if (out_spikes !== 8'h01) begin errors++; $display("FAIL repeat_out got %h expected 01", out_spikes); end
        read_vmem(0, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL repeat_vmem0 got %0d expected 0", v); end
        checks++; if (rd_q.size() !== 16) begin errors++; $display("FAIL repeat_read_count got %0d expected 16", rd_q.size()); end
        for (int k = 0; k < 16; k++) begin
            exp_a = (k / 2) * 16 + (k % 2) * 2;
            checks++;
            if (k >= rd_q.size()) begin
                errors++; $display("FAIL repeat_addr%0d got none expected %0d", k, exp_a);
            end else if (rd_q[k] !== exp_a) begin
                errors++; $display("FAIL repeat_addr%0d got %0d expected %0d", k, rd_q[k], exp_a);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [SIZE-1:0] v;
        wmem[16] = 8'd20;
        in_spikes = 16'h0005; beta = 8'd1; v_th = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (60) begin @(posedge clk); #1; end
        read_vmem(0, v);
        checks++; if (v !== 8'd7) begin errors++; $display("FAIL midrun_vmem0 got %0d expected 7", v); end
        checks++; if (out_spikes !== 8'h02) begin errors++; $display("FAIL midrun_out got %h expected 02", out_spikes); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b expected 0", done); end
        checks++; if (out_spikes !== 8'h00) begin errors++; $display("FAIL midrst_out got %h expected 00", out_spikes); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            read_vmem(k, v);
            checks++; if (v !== 8'd0) begin errors++; $display("FAIL midrst_vmem%0d got %0d expected 0", k, v); end
        end
        wmem[16] = 8'd0;
        $display("mid-run reset applied");
    endtask

    task automatic test_ignore_while_busy();
        int lat, nd;
        logic [SIZE-1:0] v;
        do_run(16'h0005, 8'd1, 8'd10, 1'b1, lat, nd);
        checks++; if (lat !== 152) begin errors++; $display("FAIL busy_latency got %0d expected 152", lat); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL busy_done_pulses got %0d expected 1", nd); end
        checks++; if (rd_q.size() !== 16) begin errors++; $display("FAIL busy_read_count got %0d expected 16", rd_q.size()); end
        checks++; if (out_spikes !== 8'h00) begin errors++; $display("FAIL busy_out got %h expected 00", out_spikes); end
        read_vmem(0, v);
        checks++; if (v !== 8'd7) begin errors++; $display("FAIL busy_vmem0 got %0d expected 7", v); end
    endtask

    task automatic test_zero_spikes();
        int lat, nd;
        logic [SIZE-1:0] v;
        do_run(16'h0000, 8'd0, 8'd10, 1'b0, lat, nd);
        checks++; if (lat !== 136) begin errors++; $display("FAIL zero_latency got %0d expected 136", lat); end
        checks++; if (rd_q.size() !== 0) begin errors++; $display("FAIL zero_reads got %0d expected 0", rd_q.size()); end
        checks++; if (out_spikes !== 8'h00) begin errors++; $display("FAIL zero_out got %h expected 00", out_spikes); end
        for (int k = 0; k < N_OUT; k++) begin
            read_vmem(k, v);
            checks++; if (v !== 8'd0) begin errors++; $display("FAIL zero_vmem%0d got %0d expected 0", k, v); end
        end
    endtask

    task automatic test_clear_and_start();
        int lat, nd, busy_seen;
        logic [SIZE-1:0] v;
        wmem[16] = 8'd5;
        do_run(16'h0005, 8'd1, 8'd10, 1'b0, lat, nd);
        do_run(16'h0005, 8'd1, 8'd10, 1'b0, lat, nd);
        checks++; if (out_spikes !== 8'h01) begin errors++; $display("FAIL pre_clear_out got %h expected 01", out_spikes); end
        read_vmem(1, v);
        checks++; if (v !== 8'd10) begin errors++; $display("FAIL pre_clear_vmem1 got %0d expected 10", v); end
        clear_vmem = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clear_vmem = 1'b0; start = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy || done) busy_seen++;
            @(posedge clk); #1;
        end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL clear_busy_cycles got %0d expected 0", busy_seen); end
        checks++; if (out_spikes !== 8'h00) begin errors++; $display("FAIL clear_out got %h expected 00", out_spikes); end
        read_vmem(1, v);
        checks++; if (v !== 8'd0) begin errors++; $display("FAIL clear_vmem1 got %0d expected 0", v); end
        $display("clear with start applied");
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; clear_vmem = 1'b0;
        in_spikes = '0; beta = '0; v_th = '0; vmem_rd_idx = '0; w_rdata = '0;
        for (int k = 0; k < 128; k++) wmem[k] = 8'd0;
        wmem[0] = 8'd3;
        wmem[2] = 8'd4;
        test_reset();
        test_first_timestep();
        test_repeat();
        test_reset_midrun();
        test_ignore_while_busy();
        test_zero_spikes();
        test_clear_and_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
